// File: rtl/v_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: FSM state
// encoding and the counter-width helper.
package v_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one so a single-digit
  // configuration still has a legal counter.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/v_sub_digit.sv
// One DIGIT-bit slice of the subtractor: difference and borrow-out of
// a - b - bin. Purely combinational; the borrow chain between digits is
// closed through the caller's borrow register.
module v_sub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // The extra MSB of the (DIGIT+1)-bit result goes to 1 exactly when the
  // slice underflows, which is the borrow-out.
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};

endmodule

// File: rtl/v_serial_subtractor.sv
// Digit-serial unsigned subtractor with borrow out. Accepts A/B on a
// valid/ready handshake, processes DIGIT bits per cycle for WIDTH/DIGIT
// cycles, then presents DIFF = A - B (mod 2^WIDTH) and BO = (A < B) until
// the consumer takes them.
module v_serial_subtractor
  import v_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             c,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = clog2_min1(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Refuse to build a configuration where the digits do not tile the word.
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("v_serial_subtractor: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [DIGIT-1:0] dig_d;
  logic             dig_bout;

  v_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .bin  (borrow),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // New digit enters at the MSB end; after N shifts the first digit sits at
  // bit 0 and the word is in natural order.
  assign res_next = WIDTH'({dig_d, res_sr} >> DIGIT);

  assign in_ready  = (state == S_IDLE) && !r;
  assign out_valid = (state == S_DONE);

  // State register; reset wins over every other input.
  always_ff @(posedge c) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of block ordering.
    if (r) state <= S_IDLE;
    else   state <= state_nxt;
  end

  // Next-state logic: one pass through RUN per digit, then hold in DONE.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)   state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  if (out_ready)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, per-digit shift/subtract, result publish.
  always_ff @(posedge c) begin
    if (r) begin
      // NOTE: the operand and result shift registers are cleared too; they
      // are few flops and a known value keeps DIFF and debug views clean.
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bo     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          borrow <= dig_bout;
          cnt    <= cnt + CNT_W'(1);
          // Outputs move only on the edge that enters DONE.
          if (cnt == LAST) begin
            diff <= res_next;
            bo   <= dig_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_v_serial_subtractor.sv
// Scoreboard bench for v_serial_subtractor. Three instances (DIGIT = 2, 1, 8
// with WIDTH = 8) run the same directed and random sequence; expected results
// come from plain integer arithmetic and are queued per instance, and a
// monitor per instance pops and compares on each output handshake.
module tb_v_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: unsigned subtraction as signed integers; negative means borrow.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
    int d;
    d = int'(xa) - int'(xb);
    if (d < 0) return {1'b1, 8'(d + 256)};
    return {1'b0, 8'(d)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int DG = (g == 0) ? 2 : (g == 1) ? 1 : 8;
    localparam int N  = WIDTH / DG;

    logic             r, in_valid, in_ready, out_valid, out_ready, bo;
    logic [WIDTH-1:0] a, b, diff;
    logic [WIDTH:0]   exp_q[$];
    bit               done = 1'b0;

    v_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DG)) dut (
      .c         (clk),
      .r         (r),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bo        (bo)
    );

    function automatic string nm(input string s);
      return $sformatf("d%0d %s", DG, s);
    endfunction

    // Monitor: every accepted result must match the oldest outstanding op.
    always @(negedge clk) begin
      if (!r && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s got %h with no expectation queued", nm("result"), {bo, diff});
        end else begin
          check(nm("result"), 32'({bo, diff}), 32'(exp_q.pop_front()));
        end
      end
    end

    // Present operands once the block is ready; returns just after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
      int k = 0;
      while (!in_ready && k < 64) begin
        @(posedge clk); #1;
        k++;
      end
      if (!in_ready) check(nm("ready timeout"), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a = xa;
      b = xb;
      exp_q.push_back(model(xa, xb));
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to OUT_VALID, watching IN_READY stays low.
    task automatic wait_done();
      int lat = 0;
      bit rdy_seen = 1'b0;
      while (!out_valid && lat < 100) begin
        if (in_ready) rdy_seen = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
      check(nm("latency"), 32'(lat), 32'(N));
      check(nm("busy ready"), 32'(rdy_seen), 32'd0);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input int hold);
      out_ready = 1'b0;
      start_op(xa, xb);
      wait_done();
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    endtask

    // Stimulus for this instance.
    initial begin
      logic [WIDTH:0] e;
      r = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check(nm("reset outs"), 32'({in_ready, out_valid, bo, diff}), 32'd0);
      r = 1'b0;
      #1;
      check(nm("ready after reset"), 32'(in_ready), 32'd1);

      do_op(8'h05, 8'h03, 0);
      do_op(8'h03, 8'h05, 1);
      do_op(8'h00, 8'hFF, 0);
      do_op(8'hA5, 8'hA5, 2);
      do_op(8'hFF, 8'h00, 0);

      // Backpressure: result held, new operands refused until release.
      out_ready = 1'b0;
      start_op(8'h5A, 8'hC3);
      wait_done();
      e = model(8'h5A, 8'hC3);
      in_valid = 1'b1; a = 8'h33; b = 8'h11;
      exp_q.push_back(model(8'h33, 8'h11));
      for (int i = 0; i < 6; i++) begin
        check(nm("hold"), 32'({out_valid, in_ready, bo, diff}), 32'({2'b10, e}));
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check(nm("idle after release"), 32'({out_valid, in_ready}), 32'b01);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done();
      @(posedge clk); #1;

      // Reset in the second RUN cycle abandons the operation.
      out_ready = 1'b0;
      start_op(8'h77, 8'h22);
      @(posedge clk); #1;
      r = 1'b1;
      @(posedge clk); #1;
      r = 1'b0;
      void'(exp_q.pop_back());
      #1;
      check(nm("mid-run reset"), 32'({out_valid, in_ready, bo, diff}), 32'({2'b01, 9'h000}));
      out_ready = 1'b1;
      do_op(8'h10, 8'h01, 0);

      for (int i = 0; i < 24; i++)
        do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

      repeat (2) @(posedge clk);
      check(nm("queue drained"), 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end
  end

  // Wait for all instances, bounded, then report.
  initial begin
    int cyc = 0;
    while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done)) begin
      checks++;
      errors++;
      $display("FAIL timeout got %0d cycles expected completion", cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
